// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-RAM write and status signals of the instruction-memory loader.
// master = host/testbench side, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output load_start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_hold, busy, done, error, words_loaded
  );

  modport slave (
    input  load_start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata,
    output cpu_hold, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a big-endian word count followed by big-endian
// instruction words from a byte stream and writes them into instruction RAM from word 0.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for load_start
// HDR_HI | receiving count[15:8]
// HDR_LO | receiving count[7:0]; count checked against DEPTH on transfer
// DATA   | receiving the four bytes of the next word, MSB first
// WRITE  | one-cycle RAM write of the assembled word
// DONE   | one-cycle done pulse, then back to IDLE
// ERROR  | header count too large; CPU held until a new load_start
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic         clk,
  input logic         reset_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t            state_q;
  state_t            state_nxt;

  logic [15:0]       count_q;
  logic [1:0]        byte_cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic [ADDR_W:0]   words_loaded_q;

  logic              ready;
  logic              xfer;
  logic              start;
  logic [15:0]       hdr_count;
  logic              last_word;

  // Status outputs are plain state decodes.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA: ready = 1'b1;
      default:              ready = 1'b0;
    endcase
  end

  assign xfer      = ready & bus.byte_valid;
  assign start     = bus.load_start & ((state_q == IDLE) | (state_q == ERROR));
  assign hdr_count = {count_q[15:8], bus.byte_data};
  assign last_word = ((17'(words_loaded_q) + 17'd1) == {1'b0, count_q});

  assign bus.byte_ready   = ready;
  assign bus.busy         = ready | (state_q == WRITE);
  assign bus.cpu_hold     = ready | (state_q == WRITE) | (state_q == ERROR);
  assign bus.error        = (state_q == ERROR);
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.done         = done_q;
  assign bus.words_loaded = words_loaded_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE, ERROR: begin
        if (bus.load_start) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        if (xfer) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        if (xfer) begin
          if (hdr_count == 16'd0) begin
            state_nxt = DONE;
          end else if ({1'b0, hdr_count} > DEPTH_W) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && (byte_cnt_q == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // mem_we and done are registered copies of "entering WRITE/DONE", so they are
  // high for exactly the cycle spent in those states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      byte_cnt_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      done_q         <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      mem_we_q <= (state_nxt == WRITE);
      done_q   <= (state_nxt == DONE);

      if (start) begin
        count_q        <= '0;
        byte_cnt_q     <= '0;
        mem_addr_q     <= '0;
        words_loaded_q <= '0;
      end

      case (state_q)
        HDR_HI: begin
          if (xfer) count_q[15:8] <= bus.byte_data;
        end
        HDR_LO: begin
          if (xfer) count_q[7:0] <= bus.byte_data;
        end
        DATA: begin
          if (xfer) begin
            mem_wdata_q <= {mem_wdata_q[23:0], bus.byte_data};
            byte_cnt_q  <= byte_cnt_q + 2'd1;
          end
        end
        WRITE: begin
          mem_addr_q     <= mem_addr_q + ADDR_W'(1);
          words_loaded_q <= words_loaded_q + (ADDR_W + 1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a stream-level model predicts the RAM write
// sequence and session outcome; one negedge process checks every write and status cycle.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int total = 0;
  int bad = 0;
  wr_t exp_q[$];
  wr_t cur;
  logic [31:0] sess_words[$];
  int done_cnt = 0;
  int we_cnt = 0;
  logic [31:0] last_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  int gap_pct = 0;
  bit noise_start = 1'b0;

  // Compare process: every write against the model queue, plus status relations each cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      total++;
      if ((bus.cpu_hold !== (bus.busy | bus.error)) ||
          (bus.byte_ready && !bus.busy) ||
          (bus.mem_we && (bus.byte_ready || !bus.busy)) ||
          (bus.error && (bus.busy || bus.byte_ready))) begin
        bad++;
        $display("FAIL status ready=%b busy=%b hold=%b err=%b we=%b",
                 bus.byte_ready, bus.busy, bus.cpu_hold, bus.error, bus.mem_we);
      end
      if (bus.mem_we === 1'b1) begin
        we_cnt++;
        last_data = bus.mem_wdata;
        last_addr = bus.mem_addr;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
        end else begin
          cur = exp_q.pop_front();
          if (cur.addr !== bus.mem_addr || cur.data !== bus.mem_wdata) begin
            bad++;
            $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                     bus.mem_addr, bus.mem_wdata, cur.addr, cur.data);
          end
        end
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.load_start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  // Offers one byte (with random gaps) until it is accepted on the following edge.
  task automatic send_byte(input logic [7:0] b);
    bit took = 1'b0;
    int guard = 0;
    while (!took) begin
      @(negedge clk);
      bus.load_start = noise_start && ($urandom_range(0, 3) == 0);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        took = bus.byte_ready;
      end
      guard++;
      if (!took && guard > 500) begin
        total++;
        bad++;
        $display("FAIL byte_timeout byte=%h ready=%b exp ready=1", b, bus.byte_ready);
        return;
      end
    end
  endtask

  task automatic fill_random(input int n);
    sess_words.delete();
    for (int i = 0; i < n; i++) sess_words.push_back($urandom);
  endtask

  // Model: header count decides the outcome; words land at consecutive addresses from 0.
  task automatic run_session(input int cnt, input bit do_start, input int gaps, input bit noise);
    int d0 = done_cnt;
    int guard = 0;
    bit good = (cnt > 0) && (cnt <= DEPTH);
    if (good) begin
      for (int i = 0; i < cnt; i++) exp_q.push_back('{addr: ADDR_W'(i), data: sess_words[i]});
    end
    gap_pct = gaps;
    if (do_start) pulse_start();
    send_byte(8'(cnt >> 8));
    send_byte(8'(cnt));
    if (cnt > DEPTH) begin
      go_idle();
      #1;
      check("err_flag", bus.error, 1'b1);
      check("err_hold_ready_busy", {bus.cpu_hold, bus.byte_ready, bus.busy}, 3'b100);
      check("err_words", bus.words_loaded, 0);
      return;
    end
    noise_start = noise;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 3; k >= 0; k--) send_byte(8'(sess_words[i] >> (8 * k)));
    end
    noise_start = 1'b0;
    go_idle();
    while (done_cnt == d0 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("done_seen", (done_cnt > d0), 1'b1);
    check("writes_all_seen", exp_q.size(), 0);
    check("words_loaded", bus.words_loaded, cnt);
    repeat (3) @(negedge clk);
    #1;
    check("done_single", done_cnt - d0, 1);
    check("idle_hold_busy", {bus.cpu_hold, bus.busy, bus.done}, 3'b000);
    exp_q.delete();
  endtask

  logic [7:0] ref_bytes[10];
  int ref_cnt;
  int we0;

  initial begin
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    #3;
    check("reset_outputs",
          {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done, bus.error,
           bus.words_loaded, bus.cpu_hold, bus.busy, bus.byte_ready},
          '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference stream: two words, decoded by the stream model.
    ref_bytes = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h14, 8'h00, 8'h1D, 8'h08, 8'h22};
    ref_cnt = {ref_bytes[0], ref_bytes[1]};
    sess_words.delete();
    for (int i = 0; i < ref_cnt; i++)
      sess_words.push_back({ref_bytes[2+4*i], ref_bytes[3+4*i], ref_bytes[4+4*i], ref_bytes[5+4*i]});
    check("model_cnt", ref_cnt, 2);
    check("model_w0", sess_words[0], 32'h20010014);
    check("model_w1", sess_words[1], 32'h001D0822);
    we0 = we_cnt;
    run_session(ref_cnt, 1'b1, 0, 1'b0);
    check("ref_writes", we_cnt - we0, 2);
    check("ref_last", {last_addr, last_data}, {8'd1, 32'h001D0822});
    check("ref_words_loaded", bus.words_loaded, 9'd2);

    // Empty header: done without writes.
    we0 = we_cnt;
    sess_words.delete();
    run_session(0, 1'b1, 0, 1'b0);
    check("zero_no_writes", we_cnt - we0, 0);

    // Oversize header, then restart from ERROR.
    sess_words.delete();
    run_session(257, 1'b1, 0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("err_sticky", {bus.error, bus.cpu_hold}, 2'b11);
    pulse_start();
    #1;
    check("restart_state", {bus.error, bus.busy, bus.byte_ready}, 3'b011);
    fill_random(3);
    run_session(3, 1'b0, 0, 1'b0);

    // Same four words back-to-back and with random valid gaps.
    fill_random(4);
    run_session(4, 1'b1, 0, 1'b0);
    run_session(4, 1'b1, 50, 1'b0);

    // load_start noise during DATA must be ignored.
    fill_random(5);
    run_session(5, 1'b1, 30, 1'b1);

    // Reset after two of four data bytes of the first word.
    fill_random(4);
    we0 = we_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hAB);
    send_byte(8'hCD);
    go_idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done, bus.error,
           bus.words_loaded, bus.cpu_hold, bus.busy, bus.byte_ready},
          '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("midreset_no_writes", we_cnt - we0, 0);
    run_session(4, 1'b1, 20, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      int c = $urandom_range(1, 9);
      fill_random(c);
      run_session(c, 1'b1, ($urandom_range(0, 1) != 0) ? 40 : 0, 1'($urandom_range(0, 1)));
    end

    // Depth boundary: exactly DEPTH words is legal, DEPTH+high-byte header is not.
    fill_random(DEPTH);
    run_session(DEPTH, 1'b1, 0, 1'b0);
    check("full_last_addr", last_addr, 8'd255);
    sess_words.delete();
    run_session(16'h0200, 1'b1, 0, 1'b0);
    fill_random(2);
    run_session(2, 1'b1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end
endmodule
